// File: rtl/sram_fabric_port.sv
// Fabric-side initiator for the dual-port SRAM wrapper: valid/ready request channels to
// active-low strobes, in-flight read tracking, credit-limited response FIFO and config sequencing.
module sram_fabric_port #(
    parameter int RSP_DEPTH = 4,
    parameter int BASE_LAT  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [13:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic        rd_valid,
    output logic        rd_ready,
    input  logic [13:0] rd_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    input  logic        cfg_req,
    input  logic [2:0]  cfg_conf,
    input  logic        cfg_out_reg,
    output logic        cfg_ack,
    output logic        csb,
    output logic        web,
    output logic        reb,
    output logic [13:0] addr_w,
    output logic [13:0] addr_r,
    output logic [31:0] d_fabric_in,
    output logic [2:0]  conf,
    output logic        out_reg,
    input  logic [31:0] d_fabric_out
);
    localparam int CW  = $clog2(RSP_DEPTH + 1);
    localparam int PW  = $clog2(RSP_DEPTH);
    localparam int SRL = BASE_LAT + 1;

    typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

    state_t          state, state_nxt;
    logic [SRL-1:0]  sr;
    logic [CW-1:0]   count;
    logic [PW-1:0]   wptr, rptr;
    logic [31:0]     fifo_mem [RSP_DEPTH];
    logic [7:0]      inflight;
    logic [7:0]      outstanding;
    logic            wr_fire, rd_fire, hazard, credit, push, pop;

    assign wr_ready    = rst_n & (state == RUN) & ~cfg_req;
    assign wr_fire     = wr_valid & wr_ready;
    assign hazard      = wr_fire & rd_valid & (rd_addr[8:0] == wr_addr[8:0]);
    assign outstanding = 8'(count) + inflight;
    assign credit      = outstanding < 8'(RSP_DEPTH);
    assign rd_ready    = wr_ready & credit & ~hazard;
    assign rd_fire     = rd_valid & rd_ready;

    assign web         = ~wr_fire;
    assign reb         = ~rd_fire;
    assign csb         = ~(wr_fire | rd_fire);
    assign addr_w      = wr_addr;
    assign addr_r      = rd_addr;
    assign d_fabric_in = wr_data;

    // Tap moves one stage later when the wrapper's output register is enabled.
    assign push = out_reg ? sr[BASE_LAT] : sr[BASE_LAT-1];
    assign pop  = rsp_ready & (count != '0);

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < SRL; i++) begin
            if (sr[i] && (i <= (BASE_LAT - 1 + int'(out_reg))))
                inflight = inflight + 8'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        cfg_ack   = 1'b0;
        case (state)
            RUN:     if (cfg_req) state_nxt = DRAIN;
            DRAIN:   if (inflight == '0) state_nxt = LOAD;
            LOAD: begin
                cfg_ack   = 1'b1;
                state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RUN;
            sr      <= '0;
            count   <= '0;
            wptr    <= '0;
            rptr    <= '0;
            conf    <= '0;
            out_reg <= 1'b0;
        end else begin
            state <= state_nxt;
            sr    <= {sr[SRL-2:0], rd_fire};
            if (state == LOAD) begin
                conf    <= cfg_conf;
                out_reg <= cfg_out_reg;
            end
            if (push)
                wptr <= (wptr == PW'(RSP_DEPTH - 1)) ? '0 : wptr + PW'(1);
            if (pop)
                rptr <= (rptr == PW'(RSP_DEPTH - 1)) ? '0 : rptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wptr] <= d_fabric_out;
    end

    assign rsp_data  = fifo_mem[rptr];
    assign rsp_valid = count != '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count == CW'(RSP_DEPTH)));

endmodule

// File: tb/tb_sram_fabric_port.sv
// Bench for sram_fabric_port: behavioural SRAM wrapper stand-in plus a transaction-level
// scoreboard (outstanding-read queue with ready times, row memory, config timeline).
module tb_sram_fabric_port;
    localparam int DEPTH = 4;
    localparam int BLAT  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid, rsp_ready;
    logic [13:0] wr_addr, rd_addr, addr_w, addr_r;
    logic [31:0] wr_data, rsp_data, d_fabric_in, d_fabric_out;
    logic        cfg_req, cfg_out_reg, cfg_ack, csb, web, reb, out_reg;
    logic [2:0]  cfg_conf, conf;

    always #5 clk = ~clk;

    sram_fabric_port #(.RSP_DEPTH(DEPTH), .BASE_LAT(BLAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .cfg_req(cfg_req), .cfg_conf(cfg_conf), .cfg_out_reg(cfg_out_reg), .cfg_ack(cfg_ack),
        .csb(csb), .web(web), .reb(reb), .addr_w(addr_w), .addr_r(addr_r),
        .d_fabric_in(d_fabric_in), .conf(conf), .out_reg(out_reg), .d_fabric_out(d_fabric_out)
    );

    // Wrapper stand-in: row memory, fixed-latency read pipe, garbage when no read is due.
    logic [31:0] wmem [512];
    logic [7:0]  pv;
    logic [31:0] pd [8];
    logic [31:0] garbage;

    always @(posedge clk) begin
        if (!csb && !web) wmem[addr_w[8:0]] <= d_fabric_in;
        pv      <= {pv[6:0], (!csb && !reb)};
        pd[0]   <= wmem[addr_r[8:0]];
        for (int k = 1; k < 8; k++) pd[k] <= pd[k-1];
        garbage <= $urandom;
    end

    assign d_fabric_out = pv[BLAT - 1 + int'(out_reg)] ? pd[BLAT - 1 + int'(out_reg)] : garbage;

    // Scoreboard state
    typedef struct { logic [31:0] data; int rdy; } exp_t;
    exp_t        sbq[$];
    logic [13:0] rdq[$];
    logic [31:0] mmem [512];
    int          cyc = 0, last_fire = -100, last_lat = BLAT, ack_cyc = 0;
    bit          cfg_active = 0, cfg_acked = 0, wf_last, rf_last, obs_rd_now, obs_wr_now;
    logic [2:0]  conf_exp = '0;
    logic        oreg_exp = 1'b0;
    int          n_tests = 0, n_fail = 0, obs_rd_fires = 0, obs_pops = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        bit wr_rdy_e, rd_rdy_e, wf, rf, rv_e;
        int lat, a, b;
        @(negedge clk);
        lat = BLAT + int'(oreg_exp);
        if (cfg_req && rst_n && !cfg_active) begin
            cfg_active = 1;
            a = cyc + 1;
            b = last_fire + last_lat + 1;
            ack_cyc = ((a > b) ? a : b) + 1;
        end
        wr_rdy_e = rst_n && !cfg_req;
        wf       = wr_valid && wr_rdy_e;
        rd_rdy_e = wr_rdy_e && (sbq.size() < DEPTH) &&
                   !(wf && rd_valid && rd_addr[8:0] == wr_addr[8:0]);
        rf       = rd_valid && rd_rdy_e;
        rv_e     = (sbq.size() != 0) && (sbq[0].rdy <= cyc);

        check("wr_ready", wr_ready, wr_rdy_e);
        check("rd_ready", rd_ready, rd_rdy_e);
        check("web", web, !wf);
        check("reb", reb, !rf);
        check("csb", csb, !(wf || rf));
        check("addr_w", addr_w, wr_addr);
        check("addr_r", addr_r, rd_addr);
        check("d_fabric_in", d_fabric_in, wr_data);
        check("cfg_ack", cfg_ack, cfg_active && cyc == ack_cyc);
        check("conf", conf, conf_exp);
        check("out_reg", out_reg, oreg_exp);
        check("rsp_valid", rsp_valid, rv_e);
        if (rv_e) check("rsp_data", rsp_data, sbq[0].data);

        obs_rd_now = rd_valid && rd_ready;
        obs_wr_now = wr_valid && wr_ready;
        if (obs_rd_now) obs_rd_fires++;
        if (rsp_valid && rsp_ready) obs_pops++;

        if (rv_e && rsp_ready) void'(sbq.pop_front());
        if (rf) begin
            sbq.push_back('{data: mmem[rd_addr[8:0]], rdy: cyc + lat + 1});
            last_fire = cyc;
            last_lat  = lat;
        end
        if (wf) mmem[wr_addr[8:0]] = wr_data;
        if (cfg_active && cyc == ack_cyc) begin
            conf_exp   = cfg_conf;
            oreg_exp   = cfg_out_reg;
            cfg_active = 0;
            cfg_acked  = 1;
        end
        if (!rst_n) begin
            sbq.delete();
            conf_exp   = '0;
            oreg_exp   = 1'b0;
            cfg_active = 0;
            last_fire  = -100;
        end
        wf_last = wf;
        rf_last = rf;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycle();
        rd_valid = (rdq.size() != 0);
        if (rd_valid) rd_addr = rdq[0];
        tick();
        if (rf_last) void'(rdq.pop_front());
        if (wf_last) wr_valid = 1'b0;
        if (cfg_acked) begin
            cfg_req   = 1'b0;
            cfg_acked = 0;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        rsp_ready = 1'b1;
        while ((rdq.size() != 0 || sbq.size() != 0 || wr_valid || cfg_req) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_left", rdq.size() + sbq.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            wmem[i] = $urandom;
            mmem[i] = wmem[i];
        end
        pv = '0;
        rst_n = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1; rsp_ready = 1'b0;
        wr_addr = 14'h0033; wr_data = 32'h1234_5678; rd_addr = 14'h0044;
        cfg_req = 1'b0; cfg_conf = '0; cfg_out_reg = 1'b0;

        // Reset with both request valids held high
        repeat (3) tick();
        rst_n = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
        repeat (2) cycle();

        // Single write then read of the same address
        wr_addr = 14'h0012; wr_data = 32'hDEAD_BEEF; wr_valid = 1'b1;
        cycle();
        rdq.push_back(14'h0012);
        wait_drain(40);

        // Eight back-to-back reads with responses blocked
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) rdq.push_back({5'($urandom), 9'(i + 16)});
        obs_rd_fires = 0;
        repeat (12) cycle();
        check("burst_fires", obs_rd_fires, DEPTH);
        obs_pops = 0;
        wait_drain(100);
        check("burst_pops", obs_pops, 8);

        // Same-row write and read in one cycle
        wr_addr = 14'h0105; wr_data = 32'hA5A5_0F0F; wr_valid = 1'b1;
        rdq.push_back(14'h1F05);
        cycle();
        check("hazard_wr_fire", obs_wr_now, 1'b1);
        check("hazard_rd_defer", obs_rd_now, 1'b0);
        cycle();
        check("hazard_rd_next", obs_rd_now, 1'b1);
        wait_drain(40);

        // Config change with two reads in flight
        rdq.push_back(14'h0012);
        rdq.push_back(14'h0105);
        repeat (2) cycle();
        cfg_req = 1'b1; cfg_conf = 3'd5; cfg_out_reg = 1'b1;
        for (int n = 0; n < 20 && cfg_req; n++) cycle();
        check("cfg_done", cfg_req, 1'b0);
        rdq.push_back(14'h0012);
        wait_drain(40);

        // Randomised traffic with occasional config changes
        for (int n = 0; n < 400; n++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (!wr_valid && $urandom_range(0, 1) == 1) begin
                wr_addr  = {5'($urandom), 9'($urandom_range(0, 7))};
                wr_data  = $urandom;
                wr_valid = 1'b1;
            end
            if (rdq.size() < 2 && $urandom_range(0, 1) == 1)
                rdq.push_back({5'($urandom), 9'($urandom_range(0, 7))});
            if (!cfg_req && $urandom_range(0, 79) == 0) begin
                cfg_req     = 1'b1;
                cfg_conf    = 3'($urandom);
                cfg_out_reg = 1'($urandom);
            end
            cycle();
        end
        wait_drain(300);

        // Reset with reads in flight and entries in the FIFO
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) rdq.push_back({5'd0, 9'(i + 32)});
        repeat (5) cycle();
        rst_n = 1'b0;
        rdq.delete();
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        obs_pops = 0;
        repeat (10) cycle();
        check("reset_no_stale", obs_pops, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
